// File: rtl/ay_psg_core_if.sv
// Register port between the CPU interface and the PSG core.
//   addr : register select R0-R15
//   din  : write data
//   wr   : write strobe, one clk per write
//   dout : registered read data for addr, one clk latency
interface ay_psg_core_if;
  logic [3:0] addr;
  logic [7:0] din;
  logic       wr;
  logic [7:0] dout;

  modport master (output addr, output din, output wr, input dout);
  modport slave  (input addr, input din, input wr, output dout);
endinterface

// File: rtl/ay_psg_core.sv
// AY-3-8912-compatible three-channel tone/noise/envelope generator.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   ce     : 1 MHz PSG clock-enable pulse
//   bus    : register port (addr/din/wr in, dout out)
//   ay_ch* : registered 8-bit log-scaled channel levels
module ay_psg_core (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  ay_psg_core_if.slave      bus,
  output logic [7:0]        ay_cha,
  output logic [7:0]        ay_chb,
  output logic [7:0]        ay_chc
);

  typedef enum logic {EnvRun, EnvHold} env_st_e;

  logic [15:0][7:0] regs_q, regs_d;
  logic [7:0]       dout_q;
  logic [2:0]       pre_q;
  logic             half_q;
  logic             tick, tick2;
  logic [4:0]       noise_cnt_q, noise_cnt_d;
  logic [16:0]      lfsr_q, lfsr_d;
  logic [15:0]      env_cnt_q, env_cnt_d;
  logic [3:0]       env_s_q, env_s_d;
  logic             env_dir_q, env_dir_d;
  env_st_e          env_st_q, env_st_d;
  logic [3:0]       env_lvl;
  logic [2:0][7:0]  ch_out;

  // Implemented bits per register; the rest are never stored and read 0.
  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  // Shared wrap rule: wrap when cnt+1 >= period, period 0 acting as 1.
  function automatic logic hits(input logic [15:0] cnt, input logic [15:0] per);
    logic [16:0] nxt;
    logic [16:0] lim;
    nxt = {1'b0, cnt} + 17'd1;
    lim = (per == 16'd0) ? 17'd1 : {1'b0, per};
    return nxt >= lim;
  endfunction

  function automatic logic [7:0] vol(input logic [3:0] l);
    case (l)
      4'd0:  vol = 8'd0;    4'd1:  vol = 8'd1;
      4'd2:  vol = 8'd2;    4'd3:  vol = 8'd3;
      4'd4:  vol = 8'd4;    4'd5:  vol = 8'd6;
      4'd6:  vol = 8'd8;    4'd7:  vol = 8'd11;
      4'd8:  vol = 8'd16;   4'd9:  vol = 8'd23;
      4'd10: vol = 8'd32;   4'd11: vol = 8'd45;
      4'd12: vol = 8'd64;   4'd13: vol = 8'd90;
      4'd14: vol = 8'd128;  default: vol = 8'd180;
    endcase
  endfunction

  // Post-write register view; period compares use it so a write landing
  // on a wrap edge is honoured immediately.
  always_comb begin
    regs_d = regs_q;
    if (bus.wr) regs_d[bus.addr] = bus.din & reg_mask(bus.addr);
  end

  assign tick    = ce && (pre_q == 3'd7);
  assign tick2   = tick && half_q;
  assign env_lvl = env_dir_q ? env_s_q : 4'd15 - env_s_q;

  // Noise generator
  always_comb begin
    noise_cnt_d = noise_cnt_q;
    lfsr_d      = lfsr_q;
    if (tick2) begin
      if (hits({11'd0, noise_cnt_q}, {11'd0, regs_d[6][4:0]})) begin
        noise_cnt_d = '0;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end else begin
        noise_cnt_d = noise_cnt_q + 5'd1;
      end
    end
  end

  // Envelope: level is derived from (s, dir); holding just freezes them.
  always_comb begin
    env_cnt_d = env_cnt_q;
    env_s_d   = env_s_q;
    env_dir_d = env_dir_q;
    env_st_d  = env_st_q;
    if (bus.wr && bus.addr == 4'd13) begin
      env_cnt_d = '0;
      env_s_d   = '0;
      env_dir_d = bus.din[2];
      env_st_d  = EnvRun;
    end else if (tick2) begin
      if (hits(env_cnt_q, {regs_d[12], regs_d[11]})) begin
        env_cnt_d = '0;
        if (env_st_q == EnvRun) begin
          if (env_s_q != 4'd15) begin
            env_s_d = env_s_q + 4'd1;
          end else if (!regs_q[13][3]) begin
            // s=15 with dir=0 gives level 0
            env_dir_d = 1'b0;
            env_st_d  = EnvHold;
          end else if (regs_q[13][0]) begin
            // flipping dir at s=15 inverts the held level
            if (regs_q[13][1]) env_dir_d = ~env_dir_q;
            env_st_d = EnvHold;
          end else begin
            env_s_d = '0;
            if (regs_q[13][1]) env_dir_d = ~env_dir_q;
          end
        end
      end else begin
        env_cnt_d = env_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '0;
      dout_q      <= '0;
      pre_q       <= '0;
      half_q      <= 1'b0;
      noise_cnt_q <= '0;
      lfsr_q      <= 17'd1;
      env_cnt_q   <= '0;
      env_s_q     <= '0;
      env_dir_q   <= 1'b0;
      env_st_q    <= EnvRun;
    end else begin
      regs_q      <= regs_d;
      dout_q      <= regs_d[bus.addr];
      noise_cnt_q <= noise_cnt_d;
      lfsr_q      <= lfsr_d;
      env_cnt_q   <= env_cnt_d;
      env_s_q     <= env_s_d;
      env_dir_q   <= env_dir_d;
      env_st_q    <= env_st_d;
      if (ce) begin
        pre_q <= pre_q + 3'd1;
        if (pre_q == 3'd7) half_q <= ~half_q;
      end
    end
  end

  // Per-channel tone generator and output stage
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [11:0] cnt_q, cnt_d;
    logic        bit_q, bit_d;
    logic [11:0] per;
    logic [3:0]  lvl;
    logic        gate;
    logic [7:0]  out_q;

    assign per  = {regs_d[2*g+1][3:0], regs_d[2*g]};
    assign lvl  = regs_q[8+g][4] ? env_lvl : regs_q[8+g][3:0];
    assign gate = (bit_q | regs_q[7][g]) & (lfsr_q[0] | regs_q[7][3+g]);

    always_comb begin
      cnt_d = cnt_q;
      bit_d = bit_q;
      if (tick) begin
        if (hits({4'd0, cnt_q}, {4'd0, per})) begin
          cnt_d = '0;
          bit_d = ~bit_q;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        bit_q <= 1'b0;
        out_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        bit_q <= bit_d;
        out_q <= gate ? vol(lvl) : 8'd0;
      end
    end

    assign ch_out[g] = out_q;
  end

  assign bus.dout = dout_q;
  assign ay_cha   = ch_out[0];
  assign ay_chb   = ch_out[1];
  assign ay_chc   = ch_out[2];

endmodule
